// File: rtl/rx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// rx_fifo_pkg
// Shared constants and helpers for the parametrised receive FIFO.
//   DEFAULT_DATA_WIDTH / DEFAULT_DEPTH : default build geometry
//   cnt_t                              : count/pointer type for the default depth
//   flags_t / calc_flags()             : status flags derived from an occupancy
// -----------------------------------------------------------------------------
package rx_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 8;
  localparam int DEFAULT_CNT_W      = $clog2(DEFAULT_DEPTH) + 1;

  // One extra bit over the address width so that DEPTH itself is representable.
  typedef logic [DEFAULT_CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic almost_empty;
  } flags_t;

  // Status flags for a given occupancy; used on the next-count so the
  // registered flags line up with the registered count.
  function automatic flags_t calc_flags(input int cnt, input int depth,
                                        input int af_thresh, input int ae_thresh);
    flags_t f;
    f.empty        = (cnt == 0);
    f.full         = (cnt == depth);
    f.almost_full  = (cnt >= af_thresh);
    f.almost_empty = (cnt <= ae_thresh);
    return f;
  endfunction

endpackage : rx_fifo_pkg

// File: rtl/fifo_regfile.sv
// -----------------------------------------------------------------------------
// fifo_regfile
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read.
//   clk     : write clock, rising edge
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
// -----------------------------------------------------------------------------
module fifo_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]    o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; occupancy is tracked by the pointers and count,
  // so stale words are never observable, and a reset-free array maps to plain
  // flops or LUT RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : fifo_regfile

// File: rtl/rx_fifo_param.sv
// -----------------------------------------------------------------------------
// rx_fifo_param
// Parametrised show-ahead receive FIFO between the byte-assembly stage and the
// host read side.
//   clk, n_rst          : clock (rising edge), async active-low reset
//   w_enable, w_data    : push request and word
//   r_enable            : pop request
//   r_data              : head word, 0 while empty
//   empty, full         : count == 0 / count == DEPTH
//   almost_full/_empty  : count >= AF_THRESH / count <= AE_THRESH
//   count               : occupancy 0..DEPTH
// Optional macro RX_FIFO_ERR_FLAGS_EN adds:
//   overrun, underrun   : sticky error flags (dropped push / pop while empty)
//   err_clear           : clears the sticky flags (a same-cycle set wins)
// -----------------------------------------------------------------------------
module rx_fifo_param
  import rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     w_enable,
  input  logic [DATA_WIDTH-1:0]    w_data,
  input  logic                     r_enable,
  output logic [DATA_WIDTH-1:0]    r_data,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
`ifdef RX_FIFO_ERR_FLAGS_EN
  input  logic                     err_clear,
  output logic                     overrun,
  output logic                     underrun,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]         r_wptr, r_rptr, r_count, w_count_nxt;
  logic                  r_empty, r_full, r_almost_full, r_almost_empty;
  logic                  w_push, w_pop;
  flags_t                w_flags;
  logic [DATA_WIDTH-1:0] w_rdata;

  // A push into a full FIFO is only legal when a pop frees the slot this edge.
  assign w_push = w_enable && (!r_full || r_enable);
  assign w_pop  = r_enable && !r_empty;

  // NOTE: every variable written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
    w_flags = calc_flags(int'(w_count_nxt), DEPTH, AF_THRESH, AE_THRESH);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + CW'(1);
      if (w_pop)  r_rptr <= r_rptr + CW'(1);
      r_count        <= w_count_nxt;
      r_empty        <= w_flags.empty;
      r_full         <= w_flags.full;
      r_almost_full  <= w_flags.almost_full;
      r_almost_empty <= w_flags.almost_empty;
    end
  end

  // The low pointer bits address storage; the extra MSB only makes the
  // pointer distance equal the occupancy, checked below.
  fifo_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (w_data),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  a_ptr_distance : assert property (@(posedge clk) disable iff (!n_rst)
    CW'(r_wptr - r_rptr) == r_count);

  // Show-ahead head word; forced to zero so stale storage never leaks out.
  assign r_data       = r_empty ? '0 : w_rdata;
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;

`ifdef RX_FIFO_ERR_FLAGS_EN
  logic r_overrun, r_underrun;
  logic w_overrun_set, w_underrun_set;

  assign w_overrun_set  = w_enable && r_full && !r_enable;
  // Includes the empty push+pop case: the push lands, the pop is still illegal.
  assign w_underrun_set = r_enable && r_empty;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_overrun  <= w_overrun_set  || (r_overrun  && !err_clear);
      r_underrun <= w_underrun_set || (r_underrun && !err_clear);
    end
  end

  assign overrun  = r_overrun;
  assign underrun = r_underrun;
`else
  // Without the error flags, dropped pushes and empty pops are silently ignored.
`endif

endmodule : rx_fifo_param

// File: tb/tb_rx_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_rx_fifo_param
// Self-checking bench for rx_fifo_param (DATA_WIDTH=8, DEPTH=8, AF=6, AE=1).
// A queue-based reference model predicts status and head word each cycle;
// words the model says are popped go into a scoreboard queue that an
// independent monitor compares against r_data whenever the DUT accepts a pop.
// Honors RX_FIFO_ERR_FLAGS_EN for the optional error-flag ports.
// -----------------------------------------------------------------------------
module tb_rx_fifo_param;
  import rx_fifo_pkg::*;

  localparam int DW  = 8;
  localparam int DEP = 8;
  localparam int AF  = 6;
  localparam int AE  = 1;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          w_enable;
  logic [DW-1:0] w_data;
  logic          r_enable;
  logic [DW-1:0] r_data;
  logic          empty, full, almost_full, almost_empty;
  cnt_t          count;
`ifdef RX_FIFO_ERR_FLAGS_EN
  logic          err_clear;
  logic          overrun, underrun;
`endif

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model_q[$];   // reference FIFO contents
  logic [DW-1:0] exp_q[$];     // scoreboard: words expected on accepted pops
  logic          m_ovr = 1'b0;
  logic          m_und = 1'b0;

  always #5 clk = ~clk;

  rx_fifo_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEP),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .w_enable     (w_enable),
    .w_data       (w_data),
    .r_enable     (r_enable),
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`ifdef RX_FIFO_ERR_FLAGS_EN
    .err_clear    (err_clear),
    .overrun      (overrun),
    .underrun     (underrun),
`endif
    .count        (count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare every visible output against the model's current state.
  task automatic check_state(input string tag);
    int n;
    n = model_q.size();
    check({tag, ":count"},        32'(count),        32'(n));
    check({tag, ":empty"},        32'(empty),        32'(n == 0));
    check({tag, ":full"},         32'(full),         32'(n == DEP));
    check({tag, ":almost_full"},  32'(almost_full),  32'(n >= AF));
    check({tag, ":almost_empty"}, 32'(almost_empty), 32'(n <= AE));
    check({tag, ":r_data"},       32'(r_data),       32'((n == 0) ? 8'h00 : model_q[0]));
`ifdef RX_FIFO_ERR_FLAGS_EN
    check({tag, ":overrun"},      32'(overrun),      32'(m_ovr));
    check({tag, ":underrun"},     32'(underrun),     32'(m_und));
`endif
  endtask

  // One clock: check state, drive inputs, advance the model, take the edge.
  task automatic cycle(input string tag, input logic we, input logic [DW-1:0] wd,
                       input logic re, input logic ec);
    int  n;
    bit  push_ok, pop_ok, ovr_set, und_set;
    check_state(tag);
    w_enable = we;
    w_data   = wd;
    r_enable = re;
`ifdef RX_FIFO_ERR_FLAGS_EN
    err_clear = ec;
`endif
    n       = model_q.size();
    push_ok = we && (n < DEP || re);
    pop_ok  = re && (n > 0);
    ovr_set = we && (n == DEP) && !re;
    und_set = re && (n == 0);
    if (pop_ok)  exp_q.push_back(model_q.pop_front());
    if (push_ok) model_q.push_back(wd);
    m_ovr = ovr_set || (m_ovr && !ec);
    m_und = und_set || (m_und && !ec);
    @(posedge clk);
    #1;
  endtask

  // Monitor: whenever the DUT is about to accept a pop, its head word must be
  // the next word the model retired.
  always @(negedge clk) begin
    if (n_rst && r_enable && !empty) begin
      if (exp_q.size() == 0)
        check("monitor:unexpected_pop", 32'(r_data), 32'hFFFF_FFFF);
      else
        check("monitor:pop_data", 32'(r_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst    = 1'b0;
    w_enable = 1'b0;
    w_data   = '0;
    r_enable = 1'b0;
`ifdef RX_FIFO_ERR_FLAGS_EN
    err_clear = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #3 n_rst = 1'b1;
    @(posedge clk); #1;

    // 1. reset state, one idle cycle
    cycle("idle", 0, 8'h00, 0, 0);

    // 2. first push latency, second push keeps head
    cycle("push_a5", 1, 8'hA5, 0, 0);
    cycle("push_3c", 1, 8'h3C, 0, 0);
    cycle("drain2a", 0, 8'h00, 1, 0);
    cycle("drain2b", 0, 8'h00, 1, 0);

    // 3. fill to full, dropped push, drain
    for (int i = 1; i <= 8; i++) cycle("fill", 1, 8'(i), 0, 0);
    cycle("push_full", 1, 8'hFF, 0, 0);
    cycle("after_drop", 0, 8'h00, 0, 1);
    for (int i = 0; i < 8; i++) cycle("drain", 0, 8'h00, 1, 0);

    // 4. full + simultaneous push/pop, then drain to see 0x99 last
    for (int i = 0; i < 8; i++) cycle("refill", 1, 8'h10 + 8'(i), 0, 0);
    cycle("full_pushpop", 1, 8'h99, 1, 0);
    for (int i = 0; i < 8; i++) cycle("drain99", 0, 8'h00, 1, 0);

    // 5. empty + simultaneous push/pop, then clear errors
    cycle("empty_pushpop", 1, 8'h42, 1, 0);
    cycle("err_clear", 0, 8'h00, 0, 1);
    cycle("drain42", 0, 8'h00, 1, 0);
    cycle("pop_empty", 0, 8'h00, 1, 0);
    cycle("clear2", 0, 8'h00, 0, 1);

    // 6. async reset mid-cycle with data present
    for (int i = 0; i < 5; i++) cycle("fill5", 1, 8'hC0 + 8'(i), 0, 0);
    w_enable = 1'b0;
    r_enable = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    model_q.delete();
    m_ovr = 1'b0;
    m_und = 1'b0;
    check_state("async_rst");
    @(posedge clk);
    #2 n_rst = 1'b1;
    cycle("post_rst_push", 1, 8'h77, 0, 0);
    cycle("post_rst_head", 0, 8'h00, 1, 0);

    // wrap: three full fill/drain rounds with random data
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEP; i++) cycle("wrap_fill", 1, 8'($urandom), 0, 0);
      for (int i = 0; i < DEP; i++) cycle("wrap_drain", 0, 8'h00, 1, 0);
    end

    // randomized traffic with shifting push/pop bias to reach both extremes
    for (int blk = 0; blk < 6; blk++) begin
      int pw, pr;
      pw = (blk % 2 == 0) ? 75 : 30;
      pr = (blk % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 250; i++)
        cycle("random",
              ($urandom_range(0, 99) < pw),
              8'($urandom),
              ($urandom_range(0, 99) < pr),
              ($urandom_range(0, 99) < 10));
    end

    // drain and final consistency
    while (model_q.size() > 0) cycle("final_drain", 0, 8'h00, 1, 0);
    cycle("final_idle", 0, 8'h00, 0, 0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rx_fifo_param
